// File: rtl/mem_port_arbiter_if.sv
// Bundle of the two requester ports, the shared memory port and the arbiter
// status outputs. The arbiter uses the slave view. Requesters and the memory
// use the master view.
interface mem_port_arbiter_if;
  // Requester side
  logic        req0;
  logic        req1;
  logic        we0;
  logic        we1;
  logic [31:0] adr0;
  logic [31:0] adr1;
  logic [31:0] wd0;
  logic [31:0] wd1;
  logic        done0;
  logic        done1;
  logic [31:0] rdata;

  // Memory side
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_adr;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  // Status
  logic        busy;
  logic        owner;

  modport slave (
    input  req0, req1, we0, we1, adr0, adr1, wd0, wd1, mem_rd,
    output done0, done1, rdata, mem_en, mem_we, mem_adr, mem_wd, busy, owner
  );

  modport master (
    output req0, req1, we0, we1, adr0, adr1, wd0, wd1, mem_rd,
    input  done0, done1, rdata, mem_en, mem_we, mem_adr, mem_wd, busy, owner
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter for the unified memory port of the multicycle core.
// Port 0 (core) has fixed priority. Port 1 (loader/DMA) is guaranteed a grant
// after MAX_CONSEC consecutive port-0 wins while it waits. Each access runs
// through IDLE -> ACCESS -> [WAIT] -> DONE. The winner's command is registered,
// and every output comes from a register or is decoded from state. A request
// never reaches the memory port combinationally.
module mem_port_arbiter #(
  parameter int unsigned RD_LAT     = 1,  // read latency after ACCESS, 1..4
  parameter int unsigned MAX_CONSEC = 4   // port-0 streak limit while port 1 waits, 1..15
) (
  input logic               clk,
  input logic               reset_n,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StWait   = 2'd2,
    StDone   = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  wait_q, wait_d;
  logic [3:0]  consec_q, consec_d;
  logic        owner_q, owner_d;
  logic        we_q, we_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] wd_q, wd_d;
  logic [31:0] rdata_q, rdata_d;

  logic        any_req;
  logic        grant1;
  logic        streak_full;

  // Arbitration decision, only consumed while idle
  always_comb begin
    any_req     = bus.req0 | bus.req1;
    streak_full = (consec_q == 4'(MAX_CONSEC));
    // Port 1 wins when alone, or when port 0 has used up its streak
    grant1      = bus.req1 & (~bus.req0 | streak_full);
  end

  // Next-state and command/data register updates
  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    consec_d = consec_q;
    owner_d  = owner_q;
    we_d     = we_q;
    adr_d    = adr_q;
    wd_d     = wd_q;
    rdata_d  = rdata_q;

    case (state_q)
      StIdle: begin
        if (any_req) begin
          owner_d = grant1;
          we_d    = grant1 ? bus.we1  : bus.we0;
          adr_d   = grant1 ? bus.adr1 : bus.adr0;
          wd_d    = grant1 ? bus.wd1  : bus.wd0;
          state_d = StAccess;
          if (grant1) begin
            consec_d = 4'd0;
          end else if (bus.req1 && !streak_full) begin
            // Port 1 was passed over, so count towards its guaranteed slot
            consec_d = consec_q + 4'd1;
          end
        end
      end

      StAccess: begin
        if (we_q) begin
          state_d = StDone;
        end else begin
          state_d = StWait;
          wait_d  = 3'(RD_LAT);
        end
      end

      StWait: begin
        // A zero count cannot occur normally. Treating it like 1 avoids a lock-up.
        if (wait_q <= 3'd1) begin
          rdata_d = bus.mem_rd;
          wait_d  = 3'd0;
          state_d = StDone;
        end else begin
          wait_d = wait_q - 3'd1;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State, counters and registered command/data
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      wait_q   <= 3'd0;
      consec_q <= 4'd0;
      owner_q  <= 1'b0;
      we_q     <= 1'b0;
      adr_q    <= 32'd0;
      wd_q     <= 32'd0;
      rdata_q  <= 32'd0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      consec_q <= consec_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      adr_q    <= adr_d;
      wd_q     <= wd_d;
      rdata_q  <= rdata_d;
    end
  end

  // Outputs decoded from state and registers only
  always_comb begin
    bus.mem_en  = (state_q == StAccess);
    bus.mem_we  = (state_q == StAccess) & we_q;
    bus.busy    = (state_q != StIdle);
    // owner reads 0 when idle even though owner_q keeps the last winner
    bus.owner   = (state_q != StIdle) & owner_q;
    bus.done0   = (state_q == StDone) & ~owner_q;
    bus.done1   = (state_q == StDone) &  owner_q;
    bus.mem_adr = adr_q;
    bus.mem_wd  = wd_q;
    bus.rdata   = rdata_q;
  end

endmodule
